sram_req_arbiter: RTL and testbench

- Shares one SRAM-like memory port between instruction fetch (inst_*) and the memory stage's data access (data_*).
- Grants one request per cycle and locks the grant until the downstream accepts it.
- Tracks accepted-but-unanswered requests in an in-order owner FIFO.
- Routes each downstream data_ok/rdata back to the requester that owns the oldest outstanding transaction.

---
 rtl/sram_req_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one SRAM-like port between instruction fetch (inst_*)
// and memory-stage data access (data_*).
// - One request is granted per cycle. A grant that stalls on m_addr_ok stays
//   locked to its owner until downstream accepts it.
// - Accepted-but-unanswered requests are tracked in an in-order owner FIFO
//   that holds up to OUTSTANDING entries.
// - Each m_data_ok/m_rdata is routed to the owner of the oldest entry.
// Ports:
//   clk, resetn                      clock, async active-low reset
//   inst_* / data_* (req, wr, size, addr, wstrb, wdata)  requester inputs
//   inst_addr_ok / data_addr_ok      request accepted this cycle (combinational)
//   inst_data_ok / data_data_ok      response for that requester this cycle
//   rdata                            m_rdata broadcast to both requesters
//   m_req, m_wr, m_size, m_addr, m_wstrb, m_wdata  downstream request
//   m_addr_ok, m_data_ok, m_rdata    downstream handshake and read data
//   err                              sticky: response arrived with no outstanding entry
// Optional macro SRAM_ARB_RR_EN: round-robin priority between the two requesters
// while unlocked. When it is not defined, data has fixed priority over inst.
module sram_req_arbiter #(
  parameter int unsigned OUTSTANDING = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [3:0]        inst_wstrb,
  input  logic [31:0]       inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [3:0]        data_wstrb,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_wstrb,
  output logic [31:0]       m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [31:0]       m_rdata,
  output logic              err
);

  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  typedef enum logic {ST_UNLOCKED = 1'b0, ST_LOCKED = 1'b1} state_e;

  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        wstrb;
    logic [31:0]       wdata;
  } req_t;

  state_e                 state_q, state_d;
  logic                   lock_owner_q, lock_owner_d;
  logic [OUTSTANDING-1:0] owner_q, owner_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   err_q, err_d;
`ifdef SRAM_ARB_RR_EN
  logic                   last_owner_q, last_owner_d;
`endif

  logic grant;
  logic sel_req;
  logic head_owner;
  logic pop;
  logic can_issue;
  logic m_req_int;
  logic accept;
  req_t inst_pl, data_pl, sel_pl;

  // Pointers wrap modulo OUTSTANDING, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(OUTSTANDING - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign inst_pl = {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata};
  assign data_pl = {data_wr, data_size, data_addr, data_wstrb, data_wdata};
  assign sel_pl  = (grant == OWN_DATA) ? data_pl : inst_pl;

  // Grant selection, lock FSM next state, and owner FIFO bookkeeping.
  always_comb begin
    state_d      = state_q;
    lock_owner_d = lock_owner_q;
    owner_d      = owner_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_d        = err_q;
`ifdef SRAM_ARB_RR_EN
    last_owner_d = last_owner_q;
`endif
    grant        = OWN_INST;

    if (state_q == ST_LOCKED) begin
      grant = lock_owner_q;
    end else if (data_req && inst_req) begin
`ifdef SRAM_ARB_RR_EN
      grant = ~last_owner_q;
`else
      grant = OWN_DATA;
`endif
    end else if (data_req) begin
      grant = OWN_DATA;
    end

    sel_req    = (grant == OWN_DATA) ? data_req : inst_req;
    head_owner = owner_q[rd_ptr_q];
    pop        = m_data_ok && (count_q != '0);
    // A response in the same cycle frees a slot, so a full FIFO can still accept.
    can_issue  = (count_q < CNT_W'(OUTSTANDING)) || pop;
    m_req_int  = sel_req && can_issue;
    accept     = m_req_int && m_addr_ok;

    case (state_q)
      ST_UNLOCKED: begin
        if (m_req_int && !m_addr_ok) begin
          state_d      = ST_LOCKED;
          lock_owner_d = grant;
        end
      end
      ST_LOCKED: begin
        if (accept) begin
          state_d = ST_UNLOCKED;
        end
      end
      default: state_d = ST_UNLOCKED;
    endcase

    if (accept) begin
      owner_d[wr_ptr_q] = grant;
      wr_ptr_d          = next_ptr(wr_ptr_q);
`ifdef SRAM_ARB_RR_EN
      last_owner_d      = grant;
`endif
    end
    if (pop) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end
    if (accept && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !accept) begin
      count_d = count_q - CNT_W'(1);
    end
    if (m_data_ok && (count_q == '0)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_UNLOCKED;
      lock_owner_q <= OWN_INST;
      owner_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_owner_q <= OWN_INST;
`endif
    end else begin
      state_q      <= state_d;
      lock_owner_q <= lock_owner_d;
      owner_q      <= owner_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      err_q        <= err_d;
`ifdef SRAM_ARB_RR_EN
      last_owner_q <= last_owner_d;
`endif
    end
  end

  // Handshake outputs are combinational passthroughs. They are forced low
  // while resetn is asserted, without waiting for a clock edge.
  assign m_req        = resetn & m_req_int;
  assign m_wr         = m_req & sel_pl.wr;
  assign m_size       = m_req ? sel_pl.size  : '0;
  assign m_addr       = m_req ? sel_pl.addr  : '0;
  assign m_wstrb      = m_req ? sel_pl.wstrb : '0;
  assign m_wdata      = m_req ? sel_pl.wdata : '0;

  assign inst_addr_ok = m_req & m_addr_ok & (grant == OWN_INST);
  assign data_addr_ok = m_req & m_addr_ok & (grant == OWN_DATA);
  assign inst_data_ok = resetn & pop & (head_owner == OWN_INST);
  assign data_data_ok = resetn & pop & (head_owner == OWN_DATA);
  assign rdata        = resetn ? m_rdata : '0;
  assign err          = err_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed testbench for sram_req_arbiter in its default build
// (OUTSTANDING=2, fixed data-over-inst priority).
// Inputs change 1 time unit after the rising edge. Outputs are sampled 4 time
// units after the rising edge, before the falling edge.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] rdata;
  logic        m_req, m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_wdata;
  logic        m_addr_ok, m_data_ok;
  logic [31:0] m_rdata;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(.OUTSTANDING(2), .ADDR_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .rdata(rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #3;
  endtask

  task automatic idle();
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
  endtask

  initial begin
    // Reset: all outputs stay low even while requests and responses are driven.
    idle();
    resetn = 0;
    inst_req = 1; inst_addr = 32'h1234; m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'hdeadbeef;
    sample();
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 0);
    chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_err", 32'(err), 0);
    next_cycle();
    idle();
    resetn = 1;

    // Single read: accept in cycle 0, response in cycle 2.
    next_cycle();
    inst_req = 1; inst_addr = 32'hbfc00000; inst_size = 2; m_addr_ok = 1;
    sample();
    chk("rd_m_req", 32'(m_req), 1);
    chk("rd_m_addr", m_addr, 32'hbfc00000);
    chk("rd_m_size", 32'(m_size), 2);
    chk("rd_inst_addr_ok", 32'(inst_addr_ok), 1);
    chk("rd_data_addr_ok", 32'(data_addr_ok), 0);
    next_cycle();
    idle();
    sample();
    chk("rd_c1_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
    next_cycle();
    m_data_ok = 1; m_rdata = 32'h3c1d0001;
    sample();
    chk("rd_c2_inst_data_ok", 32'(inst_data_ok), 1);
    chk("rd_c2_data_data_ok", 32'(data_data_ok), 0);
    chk("rd_c2_rdata", rdata, 32'h3c1d0001);
    next_cycle();
    idle();

    // Contention: data wins first, then inst. Responses return in accept order.
    next_cycle();
    inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h10; m_addr_ok = 1;
    sample();
    chk("ct0_m_addr", m_addr, 32'h10);
    chk("ct0_data_addr_ok", 32'(data_addr_ok), 1);
    chk("ct0_inst_addr_ok", 32'(inst_addr_ok), 0);
    next_cycle();
    data_req = 0; data_addr = 0;
    sample();
    chk("ct1_m_addr", m_addr, 32'h100);
    chk("ct1_inst_addr_ok", 32'(inst_addr_ok), 1);
    next_cycle();
    idle();
    m_data_ok = 1;
    sample();
    chk("ct2_ok", 32'({inst_data_ok, data_data_ok}), 32'b01);
    next_cycle();
    sample();
    chk("ct3_ok", 32'({inst_data_ok, data_data_ok}), 32'b10);
    next_cycle();
    idle();

    // Lock: inst stalls on m_addr_ok for cycles 0-2 and keeps the grant against data.
    next_cycle();
    inst_req = 1; inst_addr = 32'h200;
    sample();
    chk("lk0_m_req", 32'(m_req), 1);
    chk("lk0_m_addr", m_addr, 32'h200);
    chk("lk0_inst_addr_ok", 32'(inst_addr_ok), 0);
    next_cycle();
    data_req = 1; data_addr = 32'h20;
    sample();
    chk("lk1_m_addr", m_addr, 32'h200);
    chk("lk1_data_addr_ok", 32'(data_addr_ok), 0);
    next_cycle();
    sample();
    chk("lk2_m_addr", m_addr, 32'h200);
    next_cycle();
    m_addr_ok = 1;
    sample();
    chk("lk3_m_addr", m_addr, 32'h200);
    chk("lk3_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'b10);
    next_cycle();
    inst_req = 0; inst_addr = 0;
    sample();
    chk("lk4_m_addr", m_addr, 32'h20);
    chk("lk4_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'b01);

    // Full: two entries outstanding (inst 0x200, then data 0x20).
    next_cycle();
    data_addr = 32'h30; data_wr = 1; data_wstrb = 4'hf; data_wdata = 32'hcafe0030;
    sample();
    chk("fu0_m_req", 32'(m_req), 0);
    chk("fu0_data_addr_ok", 32'(data_addr_ok), 0);
    chk("fu0_m_addr", m_addr, 0);
    next_cycle();
    m_data_ok = 1; m_rdata = 32'h0000a200;
    sample();
    chk("fu1_ok", 32'({inst_data_ok, data_data_ok}), 32'b10);
    chk("fu1_m_req", 32'(m_req), 1);
    chk("fu1_data_addr_ok", 32'(data_addr_ok), 1);
    chk("fu1_m_wdata", m_wdata, 32'hcafe0030);
    next_cycle();
    data_req = 0; data_wr = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    m_data_ok = 0;
    inst_req = 1; inst_addr = 32'h40;
    sample();
    chk("fu2_still_full_m_req", 32'(m_req), 0);
    chk("fu2_inst_addr_ok", 32'(inst_addr_ok), 0);
    next_cycle();
    inst_req = 0; inst_addr = 0; m_addr_ok = 0; m_data_ok = 1;
    sample();
    chk("fu3_ok", 32'({inst_data_ok, data_data_ok}), 32'b01);
    next_cycle();
    sample();
    chk("fu4_ok", 32'({inst_data_ok, data_data_ok}), 32'b01);
    next_cycle();
    idle();

    // Ordering: inst read, then data write, then two responses.
    next_cycle();
    inst_req = 1; inst_addr = 32'h50; inst_size = 2; m_addr_ok = 1;
    sample();
    chk("or0_inst_addr_ok", 32'(inst_addr_ok), 1);
    next_cycle();
    inst_req = 0; inst_addr = 0;
    data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h60; data_wstrb = 4'b0011; data_wdata = 32'h0000a5a5;
    sample();
    chk("or1_data_addr_ok", 32'(data_addr_ok), 1);
    chk("or1_m_wr", 32'(m_wr), 1);
    chk("or1_m_size", 32'(m_size), 1);
    chk("or1_m_wstrb", 32'(m_wstrb), 32'h3);
    chk("or1_m_wdata", m_wdata, 32'h0000a5a5);
    next_cycle();
    idle();
    m_data_ok = 1; m_rdata = 32'h11111111;
    sample();
    chk("or2_ok", 32'({inst_data_ok, data_data_ok}), 32'b10);
    chk("or2_rdata", rdata, 32'h11111111);
    next_cycle();
    sample();
    chk("or3_ok", 32'({inst_data_ok, data_data_ok}), 32'b01);
    next_cycle();
    idle();
    sample();
    chk("or4_err", 32'(err), 0);

    // Fault: a response with nothing outstanding sets a sticky err.
    next_cycle();
    m_data_ok = 1;
    sample();
    chk("ft0_ok", 32'({inst_data_ok, data_data_ok}), 0);
    chk("ft0_err", 32'(err), 0);
    next_cycle();
    m_data_ok = 0;
    sample();
    chk("ft1_err", 32'(err), 1);
    next_cycle();
    sample();
    chk("ft2_err_held", 32'(err), 1);

    // Reset mid-transaction: one entry outstanding and data locked.
    next_cycle();
    inst_req = 1; inst_addr = 32'h70; m_addr_ok = 1;
    sample();
    chk("rm0_inst_addr_ok", 32'(inst_addr_ok), 1);
    next_cycle();
    inst_req = 0; inst_addr = 0; data_req = 1; data_addr = 32'h80; m_addr_ok = 0;
    sample();
    chk("rm1_m_req", 32'(m_req), 1);
    #1;
    resetn = 0; m_data_ok = 1; m_addr_ok = 1; inst_req = 1; inst_addr = 32'h90;
    #1;
    chk("rm_async_m_req", 32'(m_req), 0);
    chk("rm_async_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 0);
    chk("rm_async_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
    chk("rm_async_err", 32'(err), 0);
    next_cycle();
    resetn = 1;
    sample();
    chk("rm2_unlocked_m_addr", m_addr, 32'h80);
    chk("rm2_data_addr_ok", 32'(data_addr_ok), 1);
    chk("rm2_no_data_ok", 32'({inst_data_ok, data_data_ok}), 0);
    next_cycle();
    idle();
    sample();
    chk("rm3_err", 32'(err), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
